// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared constants and types for the memory/IO responder
package mem_io_pkg;

  localparam logic [1:0] OFS_OUT    = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_IN     = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_MBOX  = 2;
  localparam int ST_OVF   = 3;

  localparam logic MEMRW_WRITE = 1'b1;

  typedef enum logic {
    MBOX_EMPTY = 1'b0,
    MBOX_FULL  = 1'b1
  } mbox_state_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU bus, program-load port and host streams of the responder
interface mem_io_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              MemRW;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemD;
  logic [DATA_W-1:0] MemQ;

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              overflow;

  // master: CPU plus host side driving the responder
  modport master (
    output MemRW, MemAddr, MemD, ld_en, ld_addr, ld_data, out_ready, in_valid, in_data,
    input  MemQ, out_valid, out_data, in_ready, overflow
  );

  modport slave (
    input  MemRW, MemAddr, MemD, ld_en, ld_addr, ld_data, out_ready, in_valid, in_data,
    output MemQ, out_valid, out_data, in_ready, overflow
  );
endinterface

// File: rtl/mem_io_responder_io_out_fifo.sv
// rtl/mem_io_responder_io_out_fifo.sv - synchronous output FIFO with overflow pulse
module io_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              ovf_pulse
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign ovf_pulse = push && full && !do_pop;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - word RAM plus memory-mapped output FIFO and input mailbox
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = 8'hFC
) (
  input logic             clk,
  input logic             Reset,
  mem_io_responder_if.slave bus
);

  localparam int RAM_WORDS = int'(IO_BASE);

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic [ADDR_W-1:0] ofs_full;
  logic [1:0]        io_ofs;
  logic              io_sel;
  logic              reg_hit;
  logic              cpu_wr;
  logic              wr_out;
  logic              wr_status;
  logic              wr_in;
  logic              ld_hit;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_ovf;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  mbox_state_t       mbox_state;
  logic [DATA_W-1:0] mbox_data;
  logic              mbox_valid;
  logic              overflow_q;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] mem_q;

  assign ofs_full  = bus.MemAddr - IO_BASE;
  assign io_ofs    = ofs_full[1:0];
  assign io_sel    = (bus.MemAddr >= IO_BASE);
  assign reg_hit   = io_sel && (ofs_full < ADDR_W'(4));
  assign cpu_wr    = (bus.MemRW == MEMRW_WRITE);
  assign wr_out    = cpu_wr && reg_hit && (io_ofs == OFS_OUT);
  assign wr_status = cpu_wr && reg_hit && (io_ofs == OFS_STATUS);
  assign wr_in     = cpu_wr && reg_hit && (io_ofs == OFS_IN);
  assign ld_hit    = bus.ld_en && (bus.ld_addr < IO_BASE);

  // single write port: an in-range load takes it over any CPU RAM write
  always_ff @(posedge clk) begin
    if (ld_hit) begin
      ram[bus.ld_addr] <= bus.ld_data;
    end else if (cpu_wr && !io_sel) begin
      ram[bus.MemAddr] <= bus.MemD;
    end
  end

  assign fifo_pop = !fifo_empty && bus.out_ready;

  io_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .push      (wr_out),
    .push_data (bus.MemD),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf_pulse (fifo_ovf)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      overflow_q <= 1'b0;
    end else if (fifo_ovf) begin
      overflow_q <= 1'b1;
    end else if (wr_status && bus.MemD[ST_OVF]) begin
      overflow_q <= 1'b0;
    end
  end

  // mailbox: an empty mailbox always accepts the offered word, even alongside an ack
  always_ff @(posedge clk) begin
    if (Reset) begin
      mbox_state <= MBOX_EMPTY;
      mbox_data  <= '0;
    end else begin
      case (mbox_state)
        MBOX_EMPTY: begin
          if (bus.in_valid) begin
            mbox_state <= MBOX_FULL;
            mbox_data  <= bus.in_data;
          end
        end
        MBOX_FULL: begin
          if (wr_in) begin
            mbox_state <= MBOX_EMPTY;
          end
        end
        default: mbox_state <= MBOX_EMPTY;
      endcase
    end
  end

  assign mbox_valid = (mbox_state == MBOX_FULL);

  always_comb begin
    status_word          = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_MBOX]  = mbox_valid;
    status_word[ST_OVF]   = overflow_q;
  end

  always_comb begin
    mem_q = '0;
    if (!io_sel) begin
      mem_q = ram[bus.MemAddr];
    end else if (reg_hit) begin
      case (io_ofs)
        OFS_STATUS: mem_q = status_word;
        OFS_IN:     mem_q = mbox_data;
        default:    mem_q = '0;
      endcase
    end
  end

  assign bus.MemQ      = mem_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.in_ready  = !mbox_valid;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed table, reset sequences and randomized model check
module tb_mem_io_responder;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IOB   = 8'hFC;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  mem_io_responder_if #(.DATA_W(16), .ADDR_W(8)) bus();

  mem_io_responder #(
    .DATA_W(16), .ADDR_W(8), .FIFO_DEPTH(DEPTH), .IO_BASE(IOB)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: plain arrays and a queue
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_fifo [$];
  bit          m_mv = 1'b0;
  logic [15:0] m_md = '0;
  bit          m_ovf = 1'b0;

  typedef struct {
    logic rw; logic [7:0] addr; logic [15:0] d;
    logic ld; logic [7:0] la; logic [15:0] ldat;
    logic ordy; logic iv; logic [15:0] idat;
    logic [15:0] q; logic ov; logic [15:0] od; logic ir; logic ovf;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(logic rw, logic [7:0] addr, logic [15:0] d, logic ld,
                              logic [7:0] la, logic [15:0] ldat, logic ordy, logic iv,
                              logic [15:0] idat, logic [15:0] q, logic ov, logic [15:0] od,
                              logic ir, logic ovf);
    vec_t v;
    v.rw = rw; v.addr = addr; v.d = d; v.ld = ld; v.la = la; v.ldat = ldat;
    v.ordy = ordy; v.iv = iv; v.idat = idat;
    v.q = q; v.ov = ov; v.od = od; v.ir = ir; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rw, input logic [7:0] addr, input logic [15:0] d,
                       input logic ld, input logic [7:0] la, input logic [15:0] ldat,
                       input logic ordy, input logic iv, input logic [15:0] idat);
    bus.MemRW = rw; bus.MemAddr = addr; bus.MemD = d;
    bus.ld_en = ld; bus.ld_addr = la; bus.ld_data = ldat;
    bus.out_ready = ordy; bus.in_valid = iv; bus.in_data = idat;
  endtask

  task automatic model_edge();
    bit io, pop, set_ovf;
    logic [7:0] ofs;
    io  = (bus.MemAddr >= IOB);
    ofs = bus.MemAddr - IOB;
    if (bus.ld_en && bus.ld_addr < IOB) begin
      m_ram[bus.ld_addr] = bus.ld_data; m_known[bus.ld_addr] = 1'b1;
    end else if (bus.MemRW && !io) begin
      m_ram[bus.MemAddr] = bus.MemD; m_known[bus.MemAddr] = 1'b1;
    end
    if (Reset) begin
      m_fifo.delete(); m_mv = 1'b0; m_md = '0; m_ovf = 1'b0;
    end else begin
      pop = (m_fifo.size() != 0) && bus.out_ready;
      set_ovf = 1'b0;
      if (pop) void'(m_fifo.pop_front());
      if (bus.MemRW && io && ofs == 8'd0) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.MemD);
        else set_ovf = 1'b1;
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (bus.MemRW && io && ofs == 8'd1 && bus.MemD[3]) m_ovf = 1'b0;
      if (!m_mv && bus.in_valid) begin
        m_mv = 1'b1; m_md = bus.in_data;
      end else if (m_mv && bus.MemRW && io && ofs == 8'd2) begin
        m_mv = 1'b0;
      end
    end
  endtask

  function automatic logic [15:0] m_status();
    return {12'b0, m_ovf, m_mv, m_fifo.size() == 0, m_fifo.size() == DEPTH};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_check();
    logic [7:0] ofs;
    ofs = bus.MemAddr - IOB;
    if (bus.MemAddr < IOB) begin
      if (m_known[bus.MemAddr]) chk("rand_ram_q", bus.MemQ, m_ram[bus.MemAddr]);
    end else if (ofs == 8'd1) chk("rand_status_q", bus.MemQ, m_status());
    else if (ofs == 8'd2) chk("rand_in_q", bus.MemQ, m_md);
    else chk("rand_zero_q", bus.MemQ, 16'h0000);
    chk("rand_out_valid", 16'(bus.out_valid), 16'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("rand_out_data", bus.out_data, m_fifo[0]);
    chk("rand_in_ready", 16'(bus.in_ready), 16'(!m_mv));
    chk("rand_overflow", 16'(bus.overflow), 16'(m_ovf));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    Reset = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    Reset = 1'b0;

    tbl[0]  = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0002, 0, 0,       1, 0);
    tbl[1]  = mk(0, 8'hFD, 0,       1, 8'h05, 16'h1234, 0, 0, 0,      16'h0002, 0, 0,       1, 0);
    tbl[2]  = mk(0, 8'h05, 0,       0, 0,     0,       0, 0, 0,       16'h1234, 0, 0,       1, 0);
    tbl[3]  = mk(0, 8'hFD, 0,       1, 8'hFD, 16'hFFFF, 0, 0, 0,      16'h0002, 0, 0,       1, 0);
    tbl[4]  = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0002, 0, 0,       1, 0);
    tbl[5]  = mk(1, 8'hFC, 16'hAAAA, 0, 0,    0,       0, 0, 0,       16'h0000, 0, 0,       1, 0);
    tbl[6]  = mk(1, 8'hFC, 16'hBBBB, 0, 0,    0,       0, 0, 0,       16'h0000, 1, 16'hAAAA, 1, 0);
    tbl[7]  = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0000, 1, 16'hAAAA, 1, 0);
    tbl[8]  = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0000, 1, 16'hAAAA, 1, 0);
    tbl[9]  = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0000, 1, 16'hBBBB, 1, 0);
    tbl[10] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0002, 0, 0,       1, 0);
    tbl[11] = mk(1, 8'hFC, 16'h0001, 0, 0,    0,       0, 0, 0,       16'h0000, 0, 0,       1, 0);
    tbl[12] = mk(1, 8'hFC, 16'h0002, 0, 0,    0,       0, 0, 0,       16'h0000, 1, 16'h0001, 1, 0);
    tbl[13] = mk(1, 8'hFC, 16'h0003, 0, 0,    0,       0, 0, 0,       16'h0000, 1, 16'h0001, 1, 0);
    tbl[14] = mk(1, 8'hFC, 16'h0004, 0, 0,    0,       0, 0, 0,       16'h0000, 1, 16'h0001, 1, 0);
    tbl[15] = mk(1, 8'hFC, 16'h0005, 0, 0,    0,       0, 0, 0,       16'h0000, 1, 16'h0001, 1, 0);
    tbl[16] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0009, 1, 16'h0001, 1, 1);
    tbl[17] = mk(1, 8'hFD, 16'h0008, 0, 0,    0,       0, 0, 0,       16'h0009, 1, 16'h0001, 1, 1);
    tbl[18] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0001, 1, 16'h0001, 1, 0);
    tbl[19] = mk(1, 8'hFC, 16'h5555, 0, 0,    0,       1, 0, 0,       16'h0000, 1, 16'h0001, 1, 0);
    tbl[20] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0001, 1, 16'h0002, 1, 0);
    tbl[21] = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0001, 1, 16'h0002, 1, 0);
    tbl[22] = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0000, 1, 16'h0003, 1, 0);
    tbl[23] = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0000, 1, 16'h0004, 1, 0);
    tbl[24] = mk(0, 8'hFD, 0,       0, 0,     0,       1, 0, 0,       16'h0000, 1, 16'h5555, 1, 0);
    tbl[25] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0002, 0, 0,       1, 0);
    tbl[26] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 1, 16'h00C3, 16'h0002, 0, 0,     1, 0);
    tbl[27] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 0, 0,       16'h0006, 0, 0,       0, 0);
    tbl[28] = mk(0, 8'hFE, 0,       0, 0,     0,       0, 0, 0,       16'h00C3, 0, 0,       0, 0);
    tbl[29] = mk(1, 8'hFE, 0,       0, 0,     0,       0, 1, 16'h0042, 16'h00C3, 0, 0,     0, 0);
    tbl[30] = mk(0, 8'hFD, 0,       0, 0,     0,       0, 1, 16'h0042, 16'h0002, 0, 0,     1, 0);
    tbl[31] = mk(0, 8'hFE, 0,       0, 0,     0,       0, 0, 0,       16'h0042, 0, 0,       0, 0);

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].rw, tbl[i].addr, tbl[i].d, tbl[i].ld, tbl[i].la, tbl[i].ldat,
            tbl[i].ordy, tbl[i].iv, tbl[i].idat);
      #3;
      chk($sformatf("tbl%0d_memq", i), bus.MemQ, tbl[i].q);
      chk($sformatf("tbl%0d_out_valid", i), 16'(bus.out_valid), 16'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].od);
      chk($sformatf("tbl%0d_in_ready", i), 16'(bus.in_ready), 16'(tbl[i].ir));
      chk($sformatf("tbl%0d_overflow", i), 16'(bus.overflow), 16'(tbl[i].ovf));
      tick();
    end

    // reset with three queued words, a full mailbox and a host handshake in flight
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'hFC, 16'(i * 16'h0111), 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 8'hFD, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("pre_reset_status", bus.MemQ, 16'h0004);
    Reset = 1'b1;
    drive(0, 8'hFD, 0, 0, 0, 0, 1, 1, 16'h7777);
    tick();
    Reset = 1'b0;
    drive(0, 8'hFD, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("rst_in_ready", 16'(bus.in_ready), 16'h0001);
    chk("rst_overflow", 16'(bus.overflow), 16'h0000);
    chk("rst_status", bus.MemQ, 16'h0002);
    drive(0, 8'hFE, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mbox_data", bus.MemQ, 16'h0000);
    drive(0, 8'h05, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_ram_kept", bus.MemQ, 16'h1234);
    tick();

    // overflow set then cleared by reset
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hFC, 16'(i), 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 8'hFD, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("ovf_before_reset", 16'(bus.overflow), 16'h0001);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #3;
    chk("ovf_after_reset", 16'(bus.overflow), 16'h0000);
    tick();

    // load-wins arbitration with distinct addresses
    drive(1, 8'h10, 16'hDEAD, 1, 8'h11, 16'hBEEF, 0, 0, 0);
    tick();
    drive(0, 8'h11, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ld_wins_ld_addr", bus.MemQ, 16'hBEEF);
    tick();

    for (int a = 0; a < int'(IOB); a++) begin
      drive(0, 8'hFD, 0, 1, 8'(a), 16'($urandom), 0, 0, 0);
      tick();
    end

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] addr;
      addr = ($urandom_range(0, 1) == 1) ? (IOB + 8'($urandom_range(0, 3))) : 8'($urandom);
      drive(($urandom_range(0, 9) < 3), addr, 16'($urandom),
            ($urandom_range(0, 3) == 0), 8'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 16'($urandom));
      Reset = ($urandom_range(0, 99) == 0);
      #3;
      if (!Reset) model_check();
      tick();
    end
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
